// File: rtl/definition.sv
// Shared constants and state type for the FIFO write-side scheduler.
package definition;

  localparam int DATASIZE     = 8;
  localparam int WRITE_PERIOD = 2;
  localparam int BURST_LENGTH = 1024;

  typedef enum logic {IDLE, BURST} sched_state_t;

endpackage

// File: rtl/wr_pacer.sv
// Write pacer: enforces a minimum spacing of WRITE_PERIOD cycles between write strobes.
module wr_pacer #(
  parameter int WRITE_PERIOD = definition::WRITE_PERIOD
) (
  input  logic wclk,
  input  logic wrst_n,
  input  logic load,
  output logic pace_ok
);

  localparam int PW = (WRITE_PERIOD > 1) ? $clog2(WRITE_PERIOD) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(WRITE_PERIOD - 1);

  logic [PW-1:0] pace_cnt;

  // Reload on every write, then count down to zero and hold there.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      pace_cnt <= '0;
    end else if (load) begin
      pace_cnt <= RELOAD;
    end else if (pace_cnt != '0) begin
      pace_cnt <= pace_cnt - 1'b1;
    end
  end

  assign pace_ok = (pace_cnt == '0);

endmodule

// File: rtl/fifo_wr_scheduler.sv
// Round-robin, burst-limited, paced scheduler for the async FIFO write port.
// Optional FIFO_WR_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_wr_scheduler
  import definition::*;
#(
  parameter int DATASIZE     = definition::DATASIZE,
  parameter int BURST_LEN    = definition::BURST_LENGTH,
  parameter int WRITE_PERIOD = definition::WRITE_PERIOD
) (
  input  logic                               wclk,
  input  logic                               wrst_n,
  input  logic [1:0]                         req_valid,
  input  logic [DATASIZE-1:0]                req_data0,
  input  logic [DATASIZE-1:0]                req_data1,
  output logic [1:0]                         req_ready,
  input  logic                               wfull,
  output logic                               winc,
  output logic [DATASIZE-1:0]                wdata,
  output logic [1:0]                         grant,
  output logic [$clog2(BURST_LEN+1)-1:0]     burst_cnt
`ifdef FIFO_WR_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                        stall_cnt
`endif
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

  sched_state_t  state, state_next;
  logic          owner, owner_next;
  logic          rr_ptr, rr_next;
  logic [BW-1:0] burst_next;
  logic          pace_ok;
  logic          slot;

  wr_pacer #(.WRITE_PERIOD(WRITE_PERIOD)) u_pacer (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .load    (winc),
    .pace_ok (pace_ok)
  );

  assign slot = (state == BURST) && pace_ok && !wfull;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_next;
      burst_cnt <= burst_next;
    end
  end

  // Arbitration happens only in IDLE; a burst ends on the length limit or a declined slot.
  always_comb begin
    state_next = state;
    owner_next = owner;
    rr_next    = rr_ptr;
    burst_next = burst_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_next = BURST;
          burst_next = '0;
          owner_next = (&req_valid) ? rr_ptr : req_valid[1];
        end
      end
      BURST: begin
        if (winc) begin
          burst_next = burst_cnt + 1'b1;
        end
        if ((winc && (burst_next == BURST_MAX)) || (slot && !req_valid[owner])) begin
          state_next = IDLE;
          rr_next    = ~owner;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    req_ready = '0;
    winc      = 1'b0;
    wdata     = req_data0;
    if (state == BURST) begin
      grant[owner]     = 1'b1;
      req_ready[owner] = slot;
      winc             = slot && req_valid[owner];
      if (slot && req_valid[owner] && owner) begin
        wdata = req_data1;
      end
    end
  end

`ifdef FIFO_WR_SCHED_STALL_CNT_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if ((state == BURST) && pace_ok && req_valid[owner] && wfull &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_wr_scheduler.md
# fifo_wr_scheduler

Write-side scheduler that shares the asynchronous FIFO's single write port between two producers in the write clock domain. It grants the port to one requester at a time in round-robin order, holds the grant for a burst of up to BURST_LEN words, and paces writes to WRITE_PERIOD. It never issues `winc` while `wfull` is high. It sits directly in front of the FIFO's `winc`/`wdata` inputs.

## Interface
- DATASIZE, 8, width of each data word
- BURST_LEN, 1024, maximum number of transfers per grant (≥1)
- WRITE_PERIOD, 2, minimum spacing in cycles between successive `winc` pulses (≥1; 1 = back-to-back)

Ports:
- wclk  in  1  write clock; one clock only
- wrst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester data valid
- req_data0  in  DATASIZE  requester 0 data
- req_data1  in  DATASIZE  requester 1 data
- req_ready  out  2  per-requester accept; transfer when `req_valid[i] && req_ready[i]`
- wfull  in  1  FIFO full flag, already in the wclk domain
- winc  out  1  FIFO write strobe
- wdata  out  DATASIZE  FIFO write data
- grant  out  2  one-hot current owner, 0 when idle
- burst_cnt  out  $clog2(BURST_LEN+1)  transfers completed in the current grant

## Operation
- States: IDLE and BURST. Registered: `owner`, `rr_ptr`, `pace_cnt`, `burst_cnt`.
- **IDLE**
  - `grant` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, pick the owner: the only valid requester, or `rr_ptr` if both are valid.
  - Next cycle: BURST, with `burst_cnt` = 0.
- **BURST**
  - `pace_ok` = (`pace_cnt` == 0).
  - `req_ready[owner]` = `pace_ok && !wfull`. The other bit of `req_ready` is 0.
  - `winc` = `req_valid[owner] && req_ready[owner]`.
  - `wdata` = owner's data. When `winc` = 0, `wdata` holds `req_data0`.
- **On each transfer**
  - `pace_cnt` ← WRITE_PERIOD−1.
  - `burst_cnt` increments.
- **Between transfers:** `pace_cnt` decrements, saturating at 0.
- **Release: return to IDLE** when either condition holds:
  - the transfer that makes `burst_cnt` reach BURST_LEN, or
  - `pace_ok && !wfull && !req_valid[owner]`, i.e. the owner declined a slot.
- **On release:** `rr_ptr` ← the requester that was not the owner.
- **`wfull` high:** the grant is held and no transfer occurs. Stalled cycles do not count toward the burst. `pace_cnt` keeps decrementing.
- **Reset values:** state IDLE, `rr_ptr` = 0, `owner` = 0, `pace_cnt` = 0, `burst_cnt` = 0. As a result `winc`, `req_ready` and `grant` are all 0.

## Timing
- `winc`, `wdata` and `req_ready` are combinational from registered state plus `req_valid` and `wfull`. There is zero latency from accept to FIFO write.
- Request-to-first-write latency: 1 cycle (the IDLE arbitration cycle), then the write occurs in the first BURST cycle.
- Release-to-next-grant: release cycle → 1 IDLE cycle → next BURST. Turnaround between owners is therefore at least 2 cycles.
- Pacing: with WRITE_PERIOD = 2 and a continuously valid owner, `winc` is high on alternate cycles.
- `burst_cnt` wraps back to 0 only on entry to BURST.
- Async reset mid-burst: all outputs drop to their reset values immediately, and any in-flight word is not written. Reset deassertion must already be synchronized to wclk upstream.

## Configuration
- `FIFO_WR_SCHED_STALL_CNT_EN` defined:
  - adds output `stall_cnt` [15:0];
  - it increments in every BURST cycle where `pace_ok && req_valid[owner] && wfull`;
  - it saturates at 16'hFFFF and resets to 0.
- Not defined: the port and the counter do not exist. All other behaviour is identical.

## Structure
- Shared package `definition` holds:
  - DATASIZE, WRITE_PERIOD and BURST_LENGTH, used as the parameter defaults;
  - new typedef `sched_state_t` {IDLE, BURST}.
- One sub-module, `wr_pacer`:
  - inputs: load strobe (= `winc`);
  - contains: `pace_cnt`;
  - outputs: `pace_ok`.
- Arbitration and the FSM stay in `fifo_wr_scheduler`.

## Test plan
- **Reset:** assert `wrst_n` = 0 with `req_valid` = 2'b11 → `winc` = 0, `grant` = 0, `req_ready` = 0. After release, requester 0 is granted first (`grant` = 2'b01 after 1 cycle).
- **Pacing:** WRITE_PERIOD = 2, requester 0 always valid with data 8'h00..8'h09 → 10 `winc` pulses on alternate cycles with `wdata` in order, and no write in the IDLE cycle.
- **Burst limit and round-robin:** BURST_LEN = 4, both requesters always valid → writes R0×4, R1×4, R0×4. Each grant switch shows 1 IDLE cycle, and `burst_cnt` reaches 4 on the last transfer.
- **Full stall:** hold `wfull` = 1 for 5 cycles mid-burst → `winc` = 0 and the grant is held. Writes resume on the cycle `wfull` drops, and no word is lost or duplicated. With `FIFO_WR_SCHED_STALL_CNT_EN`, `stall_cnt` = 5.
- **Early release:** the owner drops `req_valid` on a ready slot after 3 words → return to IDLE, and the other requester is granted next.
- **Reset mid-burst:** pulse `wrst_n` low for 1 cycle during BURST → outputs go to 0 asynchronously, then restart with `rr_ptr` = 0.
